// File: rtl/uart_tx_arb_pkg.sv
// ============================================================================
// uart_tx_arb_pkg: shared encodings for the UART TX arbiter.  Rev 1.0
// ============================================================================
`default_nettype none

package uart_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MON  = 2'd1,
      ST_CPU  = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_MON = 1'b0,
      OWN_CPU = 1'b1
   } owner_e;

   localparam logic [7:0] LF_CHAR = 8'h0A;

endpackage

`default_nettype wire

// File: rtl/tx_arb_fifo.sv
// ============================================================================
// tx_arb_fifo: QDEPTH-entry character queue with wrapping pointers.  Rev 1.0
// ============================================================================
`default_nettype none

module tx_arb_fifo #(
   parameter int QDEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic [$clog2(QDEPTH):0]  count,
   output logic                     full,
   output logic                     empty
);

   localparam int            AW      = $clog2(QDEPTH);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(QDEPTH);

   logic [7:0]    mem [QDEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_MAX);
   assign empty   = (count == '0);
   // A push against a full queue is dropped even if a pop happens this cycle.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arb.sv
// ============================================================================
// uart_tx_arb: line-atomic arbiter of monitor and CPU characters into the
// UART TX FIFO, with hold timeout and sticky overrun flags.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_arb #(
   parameter int QDEPTH   = 4,
   parameter int HOLD_MAX = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] mon_char,
   input  logic       mon_en,
   output logic       mon_full,
   input  logic [7:0] uart_io_char,
   input  logic       uart_io_we,
   output logic       uart_io_full,
   output logic [7:0] tx_wdata,
   output logic       tx_wten,
   input  logic       tx_fifo_full,
   output logic       mon_ovr,
   output logic       cpu_ovr
);

   import uart_tx_arb_pkg::*;

   localparam int            CW       = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);
   localparam logic [7:0]    HOLD_LIM = 8'(HOLD_MAX);

   arb_state_e    state;
   owner_e        last_owner;
   logic [7:0]    idle_cnt;
   logic [7:0]    idle_inc;
   logic [7:0]    mon_head;
   logic [7:0]    cpu_head;
   logic [CW-1:0] mon_count;
   logic [CW-1:0] cpu_count;
   logic          mon_q_full;
   logic          cpu_q_full;
   logic          mon_empty;
   logic          cpu_empty;
   logic          mon_pop;
   logic          cpu_pop;
   logic          owner_empty;
   logic [7:0]    owner_head;

   tx_arb_fifo #(.QDEPTH(QDEPTH)) u_mon_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (mon_en),
      .din   (mon_char),
      .pop   (mon_pop),
      .head  (mon_head),
      .count (mon_count),
      .full  (mon_q_full),
      .empty (mon_empty)
   );

   tx_arb_fifo #(.QDEPTH(QDEPTH)) u_cpu_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (uart_io_we),
      .din   (uart_io_char),
      .pop   (cpu_pop),
      .head  (cpu_head),
      .count (cpu_count),
      .full  (cpu_q_full),
      .empty (cpu_empty)
   );

   assign mon_full     = (mon_count == CNT_FULL);
   assign uart_io_full = (cpu_count == CNT_FULL);

   // IDLE looks like an empty owner queue, which keeps tx_wten low there.
   always_comb begin
      owner_empty = 1'b1;
      owner_head  = 8'h00;
      case (state)
         ST_MON: begin
            owner_empty = mon_empty;
            owner_head  = mon_head;
         end
         ST_CPU: begin
            owner_empty = cpu_empty;
            owner_head  = cpu_head;
         end
         default: ;
      endcase
   end

   assign tx_wten  = ~owner_empty & ~tx_fifo_full;
   assign tx_wdata = tx_wten ? owner_head : 8'h00;
   assign mon_pop  = tx_wten & (state == ST_MON);
   assign cpu_pop  = tx_wten & (state == ST_CPU);
   assign idle_inc = (idle_cnt == 8'hFF) ? idle_cnt : idle_cnt + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_owner <= OWN_CPU;
         idle_cnt   <= 8'd0;
         mon_ovr    <= 1'b0;
         cpu_ovr    <= 1'b0;
      end else begin
         if (mon_en && mon_q_full)     mon_ovr <= 1'b1;
         if (uart_io_we && cpu_q_full) cpu_ovr <= 1'b1;

         case (state)
            ST_IDLE: begin
               idle_cnt <= 8'd0;
               if (!mon_empty && (cpu_empty || last_owner == OWN_CPU)) begin
                  state      <= ST_MON;
                  last_owner <= OWN_MON;
               end else if (!cpu_empty && (mon_empty || last_owner == OWN_MON)) begin
                  state      <= ST_CPU;
                  last_owner <= OWN_CPU;
               end
            end
            ST_MON, ST_CPU: begin
               if (tx_wten && owner_head == LF_CHAR) begin
                  state <= ST_IDLE;
               end else if (tx_wten) begin
                  idle_cnt <= 8'd0;
               end else if (owner_empty) begin
                  // Back-pressure stalls leave the counter alone; only starvation counts.
                  idle_cnt <= idle_inc;
                  if (idle_inc >= HOLD_LIM) state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ============================================================================
// tb_uart_tx_arb: queue-level reference model plus directed line scenarios.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arb;

   localparam int QD   = 4;
   localparam int HOLD = 255;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] mon_char = 8'h00;
   logic       mon_en = 1'b0;
   logic       mon_full;
   logic [7:0] uart_io_char = 8'h00;
   logic       uart_io_we = 1'b0;
   logic       uart_io_full;
   logic [7:0] tx_wdata;
   logic       tx_wten;
   logic       tx_fifo_full = 1'b0;
   logic       mon_ovr;
   logic       cpu_ovr;

   int checks = 0;
   int failures = 0;

   uart_tx_arb #(.QDEPTH(QD), .HOLD_MAX(HOLD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mon_char     (mon_char),
      .mon_en       (mon_en),
      .mon_full     (mon_full),
      .uart_io_char (uart_io_char),
      .uart_io_we   (uart_io_we),
      .uart_io_full (uart_io_full),
      .tx_wdata     (tx_wdata),
      .tx_wten      (tx_wten),
      .tx_fifo_full (tx_fifo_full),
      .mon_ovr      (mon_ovr),
      .cpu_ovr      (cpu_ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: per-source character queues and who holds the line.
   logic [7:0] mq[$];
   logic [7:0] cq[$];
   logic [7:0] dlog[$];
   int         dcyc[$];
   logic [7:0] exp_q[$];
   int  cyc = 0;
   int  m_owner = 0;      // 0 none, 1 monitor, 2 cpu
   int  m_last = 2;
   int  m_idle = 0;
   bit  m_movr = 0;
   bit  m_covr = 0;
   int  msz, csz, osz, popped;
   bit  e_wten;
   logic [7:0] e_data;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         mq.delete(); cq.delete();
         m_owner = 0; m_last = 2; m_idle = 0; m_movr = 0; m_covr = 0;
         chk("rst_outputs", {18'd0, tx_wten, tx_wdata, mon_full, uart_io_full, mon_ovr, cpu_ovr}, 32'd0);
      end else begin
         msz = mq.size();
         csz = cq.size();
         osz = (m_owner == 1) ? msz : (m_owner == 2) ? csz : 0;
         e_wten = (m_owner != 0) && (osz > 0) && !tx_fifo_full;
         e_data = !e_wten ? 8'h00 : (m_owner == 1) ? mq[0] : cq[0];
         chk("tx_wten", tx_wten, e_wten);
         chk("tx_wdata", tx_wdata, e_data);
         chk("mon_full", mon_full, msz == QD);
         chk("uart_io_full", uart_io_full, csz == QD);
         chk("mon_ovr", mon_ovr, m_movr);
         chk("cpu_ovr", cpu_ovr, m_covr);
         if (tx_wten) begin
            dlog.push_back(tx_wdata);
            dcyc.push_back(cyc);
         end

         popped = -1;
         if (e_wten) popped = (m_owner == 1) ? int'(mq.pop_front()) : int'(cq.pop_front());
         if (mon_en) begin
            if (msz == QD) m_movr = 1; else mq.push_back(mon_char);
         end
         if (uart_io_we) begin
            if (csz == QD) m_covr = 1; else cq.push_back(uart_io_char);
         end

         if (m_owner == 0) begin
            if (msz > 0 && (csz == 0 || m_last == 2)) begin
               m_owner = 1; m_last = 1; m_idle = 0;
            end else if (csz > 0 && (msz == 0 || m_last == 1)) begin
               m_owner = 2; m_last = 2; m_idle = 0;
            end
         end else if (popped == 'h0A) begin
            m_owner = 0;
         end else if (popped >= 0) begin
            m_idle = 0;
         end else if (osz == 0) begin
            m_idle = (m_idle < 255) ? m_idle + 1 : 255;
            if (m_idle >= HOLD) m_owner = 0;
         end
      end
   end

   // All stimulus tasks start and end 2 time units after a rising edge.
   task automatic drive(input logic [7:0] mc, input logic me, input logic [7:0] cc, input logic ce);
      mon_char = mc; mon_en = me; uart_io_char = cc; uart_io_we = ce;
      @(posedge clk); #2;
      mon_en = 1'b0; uart_io_we = 1'b0;
   endtask

   task automatic idle_n(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("reset_now", {30'd0, tx_wten, uart_io_full}, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      tx_fifo_full = 1'b0;
      dlog.delete();
      dcyc.delete();
   endtask

   task automatic check_log(input string nm);
      chk({nm, "_len"}, dlog.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < dlog.size(); i++)
         chk($sformatf("%s_char%0d", nm, i), dlog[i], exp_q[i]);
   endtask

   int p0, n0, gap;

   initial begin
      @(posedge clk); #2;

      // "OK\r\n" from the monitor alone: back-to-back, two-cycle first latency.
      do_reset();
      drive(8'h4F, 1, 8'h00, 0);
      p0 = cyc;
      drive(8'h4B, 1, 8'h00, 0);
      drive(8'h0D, 1, 8'h00, 0);
      drive(8'h0A, 1, 8'h00, 0);
      idle_n(6);
      exp_q = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
      check_log("t1");
      chk("t1_latency", (dcyc.size() > 0) ? dcyc[0] - p0 : -1, 2);
      chk("t1_consec", (dcyc.size() > 3) ? dcyc[3] - dcyc[0] : -1, 3);

      // Simultaneous lines: monitor wins the first tie, no interleave.
      do_reset();
      drive(8'h4F, 1, 8'h68, 1);
      drive(8'h4B, 1, 8'h69, 1);
      drive(8'h0D, 1, 8'h0D, 1);
      drive(8'h0A, 1, 8'h0A, 1);
      idle_n(15);
      exp_q = '{8'h4F, 8'h4B, 8'h0D, 8'h0A, 8'h68, 8'h69, 8'h0D, 8'h0A};
      check_log("t2");
      chk("t2_no_ovr", {30'd0, mon_ovr, cpu_ovr}, 32'd0);

      // Long back-pressure stall mid-line must not release the grant.
      do_reset();
      drive(8'h31, 1, 8'h00, 0);
      drive(8'h32, 1, 8'h00, 0);
      drive(8'h33, 1, 8'h00, 0);
      tx_fifo_full = 1'b1;
      n0 = dlog.size();
      drive(8'h00, 0, 8'h78, 1);
      drive(8'h00, 0, 8'h0A, 1);
      idle_n(298);
      chk("t3_stall_quiet", dlog.size(), n0);
      tx_fifo_full = 1'b0;
      drive(8'h0A, 1, 8'h00, 0);
      idle_n(12);
      exp_q = '{8'h31, 8'h32, 8'h33, 8'h0A, 8'h78, 8'h0A};
      check_log("t3");

      // CPU line without LF: timeout at HOLD_MAX idle cycles, then monitor.
      do_reset();
      drive(8'h00, 0, 8'h41, 1);
      drive(8'h00, 0, 8'h42, 1);
      drive(8'h4D, 1, 8'h00, 0);
      drive(8'h0A, 1, 8'h00, 0);
      idle_n(300);
      exp_q = '{8'h41, 8'h42, 8'h4D, 8'h0A};
      check_log("t4");
      gap = (dcyc.size() >= 3) ? dcyc[2] - dcyc[1] : -1;
      chk("t4_release_gap", gap, 257);

      // Overrun: fifth push against a full CPU queue is dropped.
      do_reset();
      tx_fifo_full = 1'b1;
      drive(8'h00, 0, 8'h11, 1);
      drive(8'h00, 0, 8'h22, 1);
      drive(8'h00, 0, 8'h33, 1);
      chk("t5_not_full_3", uart_io_full, 1'b0);
      drive(8'h00, 0, 8'h44, 1);
      chk("t5_full_4", uart_io_full, 1'b1);
      chk("t5_ovr_before", cpu_ovr, 1'b0);
      drive(8'h00, 0, 8'h55, 1);
      chk("t5_ovr_after", cpu_ovr, 1'b1);
      chk("t5_still_full", uart_io_full, 1'b1);
      tx_fifo_full = 1'b0;
      idle_n(10);
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      check_log("t5");
      chk("t5_ovr_sticky", cpu_ovr, 1'b1);

      // Reset mid-line discards queued characters immediately.
      do_reset();
      tx_fifo_full = 1'b1;
      drive(8'h61, 1, 8'h00, 0);
      drive(8'h62, 1, 8'h00, 0);
      drive(8'h63, 1, 8'h00, 0);
      tx_fifo_full = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_wten_in_reset", tx_wten, 1'b0);
      chk("t6_wdata_in_reset", tx_wdata, 8'h00);
      idle_n(2);
      rst_n = 1'b1;
      dlog.delete();
      dcyc.delete();
      idle_n(6);
      chk("t6_empty_after", dlog.size(), 0);
      drive(8'h0A, 1, 8'h00, 0);
      idle_n(5);
      exp_q = '{8'h0A};
      check_log("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
